// File: rtl/stl_matrix_dispatcher.sv
// stl_matrix_dispatcher
// One valid/ready input beat carrying a destination mask is copied atomically
// into every selected output lane. Each lane owns a 2-entry FIFO so a stalled
// consumer only blocks beats that target it. Zero-mask beats are accepted,
// discarded, flagged on err_o and counted in a saturating drop counter.
module stl_matrix_dispatcher #(
  parameter int REQ_N = 8,
  parameter int DAT_W = 16,
  parameter int CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_vld_i,
  input  logic [REQ_N-1:0]            in_mask_i,
  input  logic [DAT_W-1:0]            in_dat_i,
  output logic                        in_rdy_o,
  output logic [REQ_N-1:0]            out_vld_o,
  output logic [REQ_N-1:0][DAT_W-1:0] out_dat_o,
  input  logic [REQ_N-1:0]            out_rdy_i,
  output logic                        err_o,
  output logic [CNT_W-1:0]            drop_cnt_o
);

  // Saturating increment for the drop counter: holds at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  logic [REQ_N-1:0][1:0][DAT_W-1:0] mem;
  logic [REQ_N-1:0][1:0]            cnt;
  logic [REQ_N-1:0]                 wr_ptr;
  logic [REQ_N-1:0]                 rd_ptr;
  logic [REQ_N-1:0]                 full;
  logic [REQ_N-1:0]                 push;
  logic [REQ_N-1:0]                 pop;
  logic                             acc;
  logic                             zero_mask;

  // Lane status, input acceptance and per-lane push/pop strobes. Ready looks
  // only at the mask and the registered full flags, so a lane that pops in the
  // same cycle as it is full still blocks a beat aimed at it.
  always_comb begin
    full      = '0;
    out_vld_o = '0;
    out_dat_o = '0;
    for (int k = 0; k < REQ_N; k++) begin
      full[k]      = (cnt[k] == 2'd2);
      out_vld_o[k] = (cnt[k] != 2'd0);
      out_dat_o[k] = mem[k][rd_ptr[k]];
    end
    in_rdy_o  = &(~in_mask_i | ~full);
    acc       = in_vld_i & in_rdy_o;
    zero_mask = (in_mask_i == '0);
    push      = acc ? in_mask_i : '0;
    pop       = out_vld_o & out_rdy_i;
  end

  // Lane FIFO storage, pointers and occupancy; all cleared by reset so no
  // stale payload survives an abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      for (int k = 0; k < REQ_N; k++) begin
        if (push[k]) begin
          mem[k][wr_ptr[k]] <= in_dat_i;
          wr_ptr[k]         <= ~wr_ptr[k];
        end
        if (pop[k]) begin
          rd_ptr[k] <= ~rd_ptr[k];
        end
        case ({push[k], pop[k]})
          2'b10:   cnt[k] <= cnt[k] + 2'd1;
          2'b01:   cnt[k] <= cnt[k] - 2'd1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  // Zero-mask beats: one-cycle error pulse and saturating drop count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_o      <= 1'b0;
      drop_cnt_o <= '0;
    end else begin
      err_o <= acc & zero_mask;
      if (acc && zero_mask) begin
        drop_cnt_o <= sat_inc(drop_cnt_o);
      end
    end
  end

endmodule

// File: doc/stl_matrix_dispatcher.md
# stl_matrix_dispatcher

Single-stream to N-stream dispatcher: one valid/ready input beat carrying a destination mask is copied atomically into every selected output lane. Each lane has its own 2-entry FIFO, so one stalled consumer never corrupts the other lanes. The block is the fan-out counterpart of the N:1 matrix arbiter in the Common library. It sits where a shared producer feeds N independent consumers, such as response return paths or broadcast configuration writes.

## Interface
- REQ_N, 8, number of output lanes (≥2)
- DAT_W, 16, payload width
- CNT_W, 16, width of the saturating drop counter
- clk  in  1  clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- in_vld_i  in  1  input beat valid
- in_mask_i  in  REQ_N  destination lanes; multi-hot allowed
- in_dat_i  in  DAT_W  input payload
- in_rdy_o  out  1  input ready
- out_vld_o  out  REQ_N  per-lane valid
- out_dat_o  out  REQ_N×DAT_W  per-lane payload, packed [REQ_N-1:0][DAT_W-1:0]
- out_rdy_i  in  REQ_N  per-lane ready
- err_o  out  1  one-cycle pulse, the cycle after a zero-mask beat is accepted
- drop_cnt_o  out  CNT_W  count of zero-mask beats, saturating at all-ones

## Operation
**Lane FIFO**
- Each lane has a 2-entry FIFO: 2 data registers, 1-bit write pointer, 1-bit read pointer, 2-bit count (0..2).
- Lane state: full[k] = (count==2).

**Input acceptance**
- in_rdy_o = AND over k of (~in_mask_i[k] | ~full[k]).
- in_rdy_o depends only on in_mask_i and registered full flags. It must not depend on in_vld_i or out_rdy_i.
- Accept: acc = in_vld_i & in_rdy_o.

**Push**
- On acc, every lane k with in_mask_i[k]=1 writes in_dat_i at its write pointer, increments count, and toggles its write pointer.
- Delivery is all-or-nothing: either every selected lane receives the beat in the same cycle, or none does.
- A partial copy is never allowed.

**Pop**
- out_vld_o[k] = (count[k]!=0).
- out_dat_o[k] = entry at read pointer[k].
- Pop[k] = out_vld_o[k] & out_rdy_i[k]: decrement count, toggle read pointer.

**Simultaneous push and pop on one lane**
- count=1: count stays 1.
- count=2: push is impossible because in_rdy_o is low for that mask, even if the lane pops in the same cycle (registered-ready rule).

**Zero mask**
- A beat with in_mask_i==0 has in_rdy_o=1, is accepted and discarded.
- err_o pulses high the next cycle.
- drop_cnt_o increments, holding at 2^CNT_W-1.

**Output rules**
- Per-lane order is FIFO.
- Once asserted, out_vld_o[k] and out_dat_o[k] stay stable until popped.
- Lanes are fully independent; there is no cross-lane ordering.

**Reset**
- Asynchronous, at any time, including mid-transfer.
- All counts, pointers and data registers clear to 0; all in-flight beats are lost.
- out_vld_o=0, out_dat_o=0, err_o=0, drop_cnt_o=0.
- in_rdy_o=1 during and after reset, because all lanes are empty.

## Timing
- Latency: a beat accepted in cycle t gives out_vld_o[k]=1 with its data in cycle t+1.
- Throughput: 1 beat/cycle per lane when out_rdy_i stays high.
- A lane drains at 1 beat/cycle from full.
- err_o and the drop_cnt_o update appear in cycle t+1 after the accepting edge.
- in_rdy_o reflects the post-edge full flags in the same cycle they change; there is no extra pipeline.
- Upstream may change in_mask_i or in_dat_i while in_vld_i=1 and not yet accepted. The block samples only at acc.

## Test plan
- **Basic unicast (REQ_N=4):** send mask=4'b0010, dat=16'hA5A5.
  - Required: at t+1, out_vld_o=4'b0010 and out_dat_o[1]=A5A5.
  - Then pop with out_rdy_i[1]=1: out_vld_o=0.
- **Broadcast under backpressure:**
  - Hold out_rdy_i[2]=0 and send 3 beats with mask=4'b1111 (0x1, 0x2, 0x3).
  - Required: the 3rd beat stalls with in_rdy_o=0; lanes 0, 1, 3 received only 0x1 and 0x2.
  - Release lane 2: 0x3 is then written to all 4 lanes in one cycle, and every lane outputs 1, 2, 3 in order.
- **Independence:**
  - Lane 0 full, then send mask=4'b0100: in_rdy_o=1, lane 2 receives the beat, lane 0 contents are unchanged.
- **Push+pop at count=1:**
  - Stream 20 beats to lane 3 with out_rdy_i[3]=1.
  - Required: 1 beat/cycle, in_rdy_o continuously 1, data order preserved.
- **Zero mask:** send 3 beats with mask=0.
  - Required: each is accepted, err_o pulses 3 times and drop_cnt_o=3, no out_vld_o assertion.
  - With CNT_W=2, 5 drops give drop_cnt_o=3.
- **Reset mid-operation:**
  - Fill lanes with 2 entries each, then assert rst for 1 cycle between clock edges.
  - Required: out_vld_o=0, drop_cnt_o=0, in_rdy_o=1 immediately, and no stale data appears after release.
